// File: rtl/blur_pkg.sv
// Shared definitions for the streaming 3x3 box-blur engine.
//   state_e      : frame-control states (IDLE / RUN / FLUSH)
//   BORDER_PASS  : border pixels output their centre value unchanged
//   BORDER_ZERO  : border pixels output zero
//   sum_w()      : accumulator width for a nine-sample sum of pix_w-bit values
//   clog2()      : counter width helper, never less than one bit
package blur_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    localparam int unsigned BORDER_PASS = 0;
    localparam int unsigned BORDER_ZERO = 1;

    // Nine samples of pix_w bits need four extra bits (9*max < 16*max).
    function automatic int unsigned sum_w(input int unsigned pix_w);
        return pix_w + 4;
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/blur_linebuf.sv
// Shift-enable line delay: dout is the value written DEPTH enables ago.
//   CLK  : clock
//   en   : shift enable (one per accepted pixel)
//   din  : pixel shifted in
//   dout : pixel shifted in DEPTH enables earlier
// Contents are intentionally not reset; they are overwritten before use.
module blur_linebuf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 24
) (
    input  logic         CLK,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] mem [DEPTH];

    // Delay chain advancing only on enable.
    always_ff @(posedge CLK) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/blur3x3_stream.sv
// Streaming 3x3 box blur over one raster-order frame, per channel in parallel.
//   CLK, RST            : clock, synchronous active-high reset
//   ST / RD             : start-of-frame pulse (taken in IDLE) / idle indicator
//   IN_VALID/READY/DATA : input pixel stream, CH channels of PIX_W bits, ch0 in LSBs
//   OUT_VALID/READY/DATA: output pixel stream, raster order
//   OUT_LAST            : flags the final pixel (IMH-1, IMW-1) of the frame
// Output (r,c) is loaded when input r*IMW+c+IMW+1 is accepted; the last IMW+1
// outputs are all border pixels and are drained in FLUSH from buffered centres.
module blur3x3_stream
    import blur_pkg::*;
#(
    parameter int unsigned IMW    = 16,
    parameter int unsigned IMH    = 16,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned CH     = 3,
    parameter int unsigned BORDER = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ST,
    output logic                  RD,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [CH*PIX_W-1:0]   IN_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [CH*PIX_W-1:0]   OUT_DATA,
    output logic                  OUT_LAST
);

    localparam int unsigned DW = CH * PIX_W;
    localparam int unsigned SW = sum_w(PIX_W);
    localparam int unsigned CW = clog2(IMW);
    localparam int unsigned RW = clog2(IMH);
    localparam bit ZERO_BORDER = (BORDER == BORDER_ZERO);

    state_e          state_q, state_d;
    logic            rd_q;
    logic [RW-1:0]   ir, pr;
    logic [CW-1:0]   ic, pc;
    logic            loaded_all_q;
    logic            out_valid_q, out_last_q;
    logic [DW-1:0]   out_data_q;

    logic            out_free_c, accept_c, flush_load_c, shift_c, load_c;
    logic            primed_c, in_last_c, out_last_pos_c, border_c;
    logic [DW-1:0]   lb1_dout, lb2_dout;
    logic [DW-1:0]   col_c [3];
    logic [DW-1:0]   blur_c, pix_c;

    // Two stored window columns; the third (newest) column is col_c.
    logic [DW-1:0]   win_q [3][2];

    assign out_free_c     = !out_valid_q || OUT_READY;
    assign IN_READY       = (state_q == S_RUN) && out_free_c;
    assign accept_c       = IN_READY && IN_VALID;
    assign flush_load_c   = (state_q == S_FLUSH) && out_free_c && !loaded_all_q;
    assign shift_c        = accept_c || flush_load_c;
    // First output needs IMW+1 pixels already behind the one being accepted.
    assign primed_c       = (ir >= RW'(2)) || ((ir == RW'(1)) && (ic != '0));
    assign load_c         = (accept_c && primed_c) || flush_load_c;
    assign in_last_c      = (ir == RW'(IMH-1)) && (ic == CW'(IMW-1));
    assign out_last_pos_c = (pr == RW'(IMH-1)) && (pc == CW'(IMW-1));
    assign border_c       = (pr == '0) || (pr == RW'(IMH-1)) ||
                            (pc == '0) || (pc == CW'(IMW-1));

    assign RD        = rd_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_LAST  = out_last_q;

    // Line delays: lb1 gives the row above, lb2 the row two above.
    blur_linebuf #(.DEPTH(IMW), .W(DW)) u_lb1 (
        .CLK  (CLK),
        .en   (shift_c),
        .din  (IN_DATA),
        .dout (lb1_dout)
    );

    blur_linebuf #(.DEPTH(IMW), .W(DW)) u_lb2 (
        .CLK  (CLK),
        .en   (shift_c),
        .din  (lb1_dout),
        .dout (lb2_dout)
    );

    // Incoming window column, top row first.
    always_comb begin
        col_c[0] = lb2_dout;
        col_c[1] = lb1_dout;
        col_c[2] = IN_DATA;
    end

    // Window shift; during FLUSH IN_DATA is stale but only feeds unused border taps.
    always_ff @(posedge CLK) begin
        if (shift_c) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= col_c[r];
            end
        end
    end

    // Per-channel nine-tap sum and floor divide by nine.
    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [SW-1:0] sum_c;

        always_comb begin
            sum_c = '0;
            for (int r = 0; r < 3; r++) begin
                sum_c = sum_c
                      + SW'(win_q[r][0][g*PIX_W +: PIX_W])
                      + SW'(win_q[r][1][g*PIX_W +: PIX_W])
                      + SW'(col_c[r][g*PIX_W +: PIX_W]);
            end
        end

        assign blur_c[g*PIX_W +: PIX_W] = PIX_W'(sum_c / SW'(9));
    end

    // Centre tap of the post-shift window is the newest stored middle-row sample.
    always_comb begin
        pix_c = blur_c;
        if (border_c) begin
            pix_c = ZERO_BORDER ? '0 : win_q[1][1];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (ST) state_d = S_RUN;
            S_RUN:   if (accept_c && in_last_c) state_d = S_FLUSH;
            S_FLUSH: if (out_valid_q && OUT_READY && out_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and output register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            rd_q         <= 1'b1;
            ir           <= '0;
            ic           <= '0;
            pr           <= '0;
            pc           <= '0;
            loaded_all_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= (state_d == S_IDLE);

            if ((state_q == S_IDLE) && ST) begin
                ir           <= '0;
                ic           <= '0;
                pr           <= '0;
                pc           <= '0;
                loaded_all_q <= 1'b0;
            end

            if (accept_c) begin
                if (ic == CW'(IMW-1)) begin
                    ic <= '0;
                    ir <= ir + RW'(1);
                end else begin
                    ic <= ic + CW'(1);
                end
            end

            // pr/pc track the position of the pixel entering the output register.
            if (load_c) begin
                if (pc == CW'(IMW-1)) begin
                    pc <= '0;
                    pr <= pr + RW'(1);
                end else begin
                    pc <= pc + CW'(1);
                end
                if (out_last_pos_c) loaded_all_q <= 1'b1;
                out_valid_q <= 1'b1;
                out_data_q  <= pix_c;
                out_last_q  <= out_last_pos_c;
            end else if (OUT_READY) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blur3x3_stream.sv
// Scoreboard bench for blur3x3_stream: one instance per border mode, shared stimulus.
module tb_blur3x3_stream;

    localparam int unsigned IMW   = 16;
    localparam int unsigned IMH   = 16;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned CH    = 3;
    localparam int unsigned DW    = CH * PIX_W;
    localparam int unsigned NPIX  = IMW * IMH;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic          CLK = 1'b0;
    logic          rst = 1'b1;
    logic          st = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] in_data = '0;

    logic          rd_a, in_ready_a, ov_a, ol_a;
    logic [DW-1:0] od_a;
    logic          rd_b, in_ready_b, ov_b, ol_b;
    logic [DW-1:0] od_b;

    int   vectors = 0;
    int   miscompares = 0;
    int   out_cnt_a = 0;
    bit   mon_en = 1'b0;
    bit   stall_mode = 1'b0;
    bit   abort = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [DW-1:0] img [NPIX];

    always #5 CLK = ~CLK;

    blur3x3_stream #(.IMW(IMW), .IMH(IMH), .PIX_W(PIX_W), .CH(CH), .BORDER(0)) u_dut_a (
        .CLK(CLK), .RST(rst), .ST(st), .RD(rd_a),
        .IN_VALID(in_valid), .IN_READY(in_ready_a), .IN_DATA(in_data),
        .OUT_VALID(ov_a), .OUT_READY(out_ready), .OUT_DATA(od_a), .OUT_LAST(ol_a)
    );

    blur3x3_stream #(.IMW(IMW), .IMH(IMH), .PIX_W(PIX_W), .CH(CH), .BORDER(1)) u_dut_b (
        .CLK(CLK), .RST(rst), .ST(st), .RD(rd_b),
        .IN_VALID(in_valid), .IN_READY(in_ready_b), .IN_DATA(in_data),
        .OUT_VALID(ov_b), .OUT_READY(out_ready), .OUT_DATA(od_b), .OUT_LAST(ol_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic fail_event(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout/unexpected event, expected normal completion", name);
    endtask

    // kind 0 flat, 1 ramp, 2 max with one hole, 3 random.
    task automatic build(input int kind);
        for (int r = 0; r < IMH; r++) begin
            for (int c = 0; c < IMW; c++) begin
                case (kind)
                    0: img[r*IMW+c] = 24'h404040;
                    1: img[r*IMW+c] = {8'(255 - (r*16 + c)), 8'(c*10), 8'(r*16 + c)};
                    2: img[r*IMW+c] = (r == 5 && c == 7) ? 24'h000000 : 24'hFFFFFF;
                    default: img[r*IMW+c] = 24'($urandom);
                endcase
            end
        end
    endtask

    function automatic logic [DW-1:0] expect_px(input int kind, input bit zero_b,
                                                input int r, input int c);
        bit            on_edge;
        logic [DW-1:0] v;
        int            s;
        on_edge = (r == 0) || (r == IMH-1) || (c == 0) || (c == IMW-1);
        v = '0;
        if (on_edge) return zero_b ? '0 : img[r*IMW+c];
        case (kind)
            0: v = 24'h404040;
            1: v = img[r*IMW+c];
            2: v = (r >= 4 && r <= 6 && c >= 6 && c <= 8) ? 24'hE2E2E2 : 24'hFFFFFF;
            default: begin
                for (int ch = 0; ch < CH; ch++) begin
                    s = 0;
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            s += int'(img[(r+dr)*IMW + (c+dc)][ch*PIX_W +: PIX_W]);
                        end
                    end
                    v[ch*PIX_W +: PIX_W] = PIX_W'(s / 9);
                end
            end
        endcase
        return v;
    endfunction

    task automatic push_expected(input int kind);
        exp_t e;
        for (int r = 0; r < IMH; r++) begin
            for (int c = 0; c < IMW; c++) begin
                e.l = (r == IMH-1) && (c == IMW-1);
                e.d = expect_px(kind, 1'b0, r, c);
                q_a.push_back(e);
                e.d = expect_px(kind, 1'b1, r, c);
                q_b.push_back(e);
            end
        end
    endtask

    task automatic start_frame();
        @(posedge CLK); #1;
        st = 1'b1;
        @(posedge CLK); #1;
        st = 1'b0;
        check("rd_busy_a", 32'(rd_a), 32'(0));
    endtask

    task automatic send_frame();
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < NPIX && !abort) begin
            @(posedge CLK); #1;
            if (abort) break;
            in_valid = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = img[idx];
            @(negedge CLK);
            if (in_valid && in_ready_a) idx++;
            guard++;
            if (guard > 20000) begin
                fail_event("send_timeout");
                break;
            end
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(rd_a && rd_b && !ov_a && !ov_b) && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20000) fail_event("idle_timeout");
        check("queue_a_drained", 32'(q_a.size()), 32'(0));
        check("queue_b_drained", 32'(q_b.size()), 32'(0));
    endtask

    task automatic run_frame(input int kind, input bit stall);
        build(kind);
        push_expected(kind);
        stall_mode = stall;
        start_frame();
        send_frame();
        wait_idle();
        stall_mode = 1'b0;
    endtask

    // Sink readiness, randomised only while stall_mode is set.
    initial begin
        forever begin
            @(posedge CLK); #1;
            out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor A: holds under back-pressure, pops and compares on handshake.
    initial begin
        exp_t          e;
        bit            hold;
        logic [DW:0]   held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge CLK);
            if (mon_en && hold) check("hold_a", 32'({ov_a, od_a, ol_a}), 32'({1'b1, held}));
            hold = mon_en && ov_a && !out_ready;
            held = {od_a, ol_a};
            if (mon_en && ov_a && out_ready) begin
                out_cnt_a++;
                if (q_a.size() == 0) begin
                    fail_event("unexpected_out_a");
                end else begin
                    e = q_a.pop_front();
                    check("data_a", 32'(od_a), 32'(e.d));
                    check("last_a", 32'(ol_a), 32'(e.l));
                end
            end
        end
    end

    // Monitor B (zero-border instance).
    initial begin
        exp_t          e;
        bit            hold;
        logic [DW:0]   held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge CLK);
            if (mon_en && hold) check("hold_b", 32'({ov_b, od_b, ol_b}), 32'({1'b1, held}));
            hold = mon_en && ov_b && !out_ready;
            held = {od_b, ol_b};
            if (mon_en && ov_b && out_ready) begin
                if (q_b.size() == 0) begin
                    fail_event("unexpected_out_b");
                end else begin
                    e = q_b.pop_front();
                    check("data_b", 32'(od_b), 32'(e.d));
                    check("last_b", 32'(ol_b), 32'(e.l));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no completion, expected summary before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_rd_a",       32'(rd_a),       32'(1));
        check("reset_in_ready_a", 32'(in_ready_a), 32'(0));
        check("reset_out_valid_a",32'(ov_a),       32'(0));
        check("reset_out_data_a", 32'(od_a),       32'(0));
        check("reset_out_last_a", 32'(ol_a),       32'(0));
        check("reset_rd_b",       32'(rd_b),       32'(1));
        check("reset_in_ready_b", 32'(in_ready_b), 32'(0));
        rst = 1'b0;
        mon_en = 1'b1;

        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        run_frame(2, 1'b0);
        run_frame(3, 1'b1);

        // Abort a frame with reset around output 100, then run a clean frame.
        build(3);
        push_expected(3);
        out_cnt_a = 0;
        start_frame();
        fork
            send_frame();
            begin
                int n;
                n = 0;
                while (out_cnt_a < 100 && n < 5000) begin
                    @(negedge CLK);
                    n++;
                end
                if (out_cnt_a < 100) fail_event("reset_point_timeout");
                abort = 1'b1;
                @(posedge CLK); #1;
                mon_en = 1'b0;
                rst = 1'b1;
                @(posedge CLK); #1;
                check("midrst_rd_a",        32'(rd_a), 32'(1));
                check("midrst_out_valid_a", 32'(ov_a), 32'(0));
                check("midrst_rd_b",        32'(rd_b), 32'(1));
                check("midrst_out_valid_b", 32'(ov_b), 32'(0));
                rst = 1'b0;
                q_a.delete();
                q_b.delete();
                mon_en = 1'b1;
            end
        join
        abort = 1'b0;
        run_frame(3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
